// File: rtl/pot_gain_seq.sv
// pot_gain_seq: periodic sweep squaring six slider readings through one shared shift-add multiplier.
// Results are gathered in shadow registers and published together with a one-cycle upd pulse.
module pot_gain_seq #(
    parameter int REFRESH_CYC = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] POT_LP,
    input  logic [11:0] POT_B1,
    input  logic [11:0] POT_B2,
    input  logic [11:0] POT_B3,
    input  logic [11:0] POT_HP,
    input  logic [11:0] VOLUME,
    input  logic        frz,
    output logic [11:0] GAIN_LP,
    output logic [11:0] GAIN_B1,
    output logic [11:0] GAIN_B2,
    output logic [11:0] GAIN_B3,
    output logic [11:0] GAIN_HP,
    output logic [11:0] GAIN_VOL,
    output logic        busy,
    output logic        upd
);
    localparam int CW = $clog2(REFRESH_CYC);

    typedef enum logic [1:0] {IDLE, LOAD, MULT, DONE} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [5:0][11:0] snap_q, snap_d;
    logic [5:0][11:0] shad_q, shad_d;
    logic [5:0][11:0] gain_q, gain_d;
    logic [2:0]       ch_q, ch_d;
    logic [3:0]       bit_q, bit_d;
    logic [23:0]      mcand_q, mcand_d;
    logic [23:0]      acc_q, acc_d, acc_sum;
    logic [11:0]      mplier_q, mplier_d;
    logic             upd_q, upd_d;
    logic             tick, start, last_bit, last_ch;

    assign tick     = cnt_q == CW'(REFRESH_CYC - 1);
    assign start    = state_q == IDLE && tick && !frz;
    assign last_bit = bit_q == 4'd11;
    assign last_ch  = ch_q == 3'd5;

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    state_d = start ? LOAD : IDLE;
            LOAD:    state_d = MULT;
            MULT:    state_d = last_bit ? (last_ch ? DONE : LOAD) : MULT;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = state_q != IDLE;
    end

    always_comb begin
        cnt_d    = tick ? '0 : cnt_q + CW'(1);
        snap_d   = start ? {VOLUME, POT_HP, POT_B3, POT_B2, POT_B1, POT_LP} : snap_q;
        shad_d   = shad_q;
        gain_d   = state_q == DONE ? shad_q : gain_q;
        ch_d     = start ? 3'd0 : ch_q;
        bit_d    = bit_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        acc_sum  = acc_q + (mplier_q[0] ? mcand_q : 24'd0);
        upd_d    = state_q == DONE;
        if (state_q == LOAD) begin
            mcand_d  = {12'd0, snap_q[ch_q]};
            mplier_d = snap_q[ch_q];
            acc_d    = '0;
            bit_d    = '0;
        end
        // one multiplier bit per cycle, LSB first; the final partial sum is the full product
        if (state_q == MULT) begin
            acc_d    = acc_sum;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            bit_d    = bit_q + 4'd1;
            if (last_bit) begin
                shad_d[ch_q] = acc_sum[23:12];
                ch_d         = ch_q + 3'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            snap_q   <= '0;
            shad_q   <= '0;
            gain_q   <= '0;
            ch_q     <= '0;
            bit_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            upd_q    <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            snap_q   <= snap_d;
            shad_q   <= shad_d;
            gain_q   <= gain_d;
            ch_q     <= ch_d;
            bit_q    <= bit_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            upd_q    <= upd_d;
        end
    end

    assign GAIN_LP  = gain_q[0];
    assign GAIN_B1  = gain_q[1];
    assign GAIN_B2  = gain_q[2];
    assign GAIN_B3  = gain_q[3];
    assign GAIN_HP  = gain_q[4];
    assign GAIN_VOL = gain_q[5];
    assign upd      = upd_q;
endmodule

// File: tb/tb_pot_gain_seq.sv
// tb_pot_gain_seq: randomized sweeps of pot_gain_seq checked against a plain squared-law model.
module tb_pot_gain_seq;
    localparam int R = 96;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             frz = 1'b0;
    logic [11:0]      pot [6];
    logic [11:0]      GAIN_LP, GAIN_B1, GAIN_B2, GAIN_B3, GAIN_HP, GAIN_VOL;
    logic             busy, upd;
    logic [5:0][11:0] gout;
    int               tests = 0;
    int               fails = 0;
    int               cyc = 0;
    int               last_start = 0;
    int               prev_start = 0;

    pot_gain_seq #(.REFRESH_CYC(R)) dut (
        .clk(clk), .rst_n(rst_n),
        .POT_LP(pot[0]), .POT_B1(pot[1]), .POT_B2(pot[2]),
        .POT_B3(pot[3]), .POT_HP(pot[4]), .VOLUME(pot[5]),
        .frz(frz),
        .GAIN_LP(GAIN_LP), .GAIN_B1(GAIN_B1), .GAIN_B2(GAIN_B2),
        .GAIN_B3(GAIN_B3), .GAIN_HP(GAIN_HP), .GAIN_VOL(GAIN_VOL),
        .busy(busy), .upd(upd)
    );

    assign gout = {GAIN_VOL, GAIN_HP, GAIN_B3, GAIN_B2, GAIN_B1, GAIN_LP};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        repeat (100000) @(posedge clk);
        $display("FAIL watchdog: simulation exceeded cycle budget");
        $fatal(1);
    end

    function automatic logic [5:0][11:0] model();
        logic [5:0][11:0] e;
        for (int c = 0; c < 6; c++) e[c] = 12'((int'(pot[c]) * int'(pot[c])) / 4096);
        return e;
    endfunction

    task automatic set_random(input int lo);
        for (int c = 0; c < 6; c++) pot[c] = 12'($urandom_range(4095, lo));
    endtask

    // waits (bounded) for busy to rise; n = negedges waited or -1 on timeout, u = upd pulses seen
    task automatic wait_start(output int n, output int u);
        n = 0;
        u = 0;
        while (busy !== 1'b1 && n < 3 * R) begin
            @(negedge clk);
            n++;
            u += int'(upd === 1'b1);
        end
        if (busy !== 1'b1) n = -1;
        prev_start = last_start;
        last_start = cyc;
    endtask

    // called at the negedge of T+1; returns at the negedge of T+81
    task automatic observe(input bit zero_at5, input bit wiggle_frz, output int bhi, output int uearly,
                           output int gchg, output logic b80, output logic u80, output logic u81,
                           output logic [5:0][11:0] g);
        logic [5:0][11:0] g0;
        g0 = gout;
        bhi = 0;
        uearly = 0;
        gchg = 0;
        for (int i = 0; i < 79; i++) begin
            bhi += int'(busy === 1'b1);
            uearly += int'(upd !== 1'b0);
            gchg += int'(gout !== g0);
            if (zero_at5 && i == 4) for (int c = 0; c < 6; c++) pot[c] = 12'd0;
            if (wiggle_frz) frz = i[0];
            @(negedge clk);
        end
        b80 = busy;
        u80 = upd;
        g = gout;
        @(negedge clk);
        u81 = upd;
    endtask

    task automatic test_reset();
        int n, u;
        pot[0] = 12'd4095; pot[1] = 12'd2048; pot[2] = 12'd1;
        pot[3] = 12'd0;    pot[4] = 12'd1024; pot[5] = 12'd3000;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests++; if (gout !== '0) begin fails++; $display("FAIL reset_gain: got %h expected 0", gout); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
        tests++; if (upd !== 1'b0) begin fails++; $display("FAIL reset_upd: got %b expected 0", upd); end
        rst_n = 1'b1;
        wait_start(n, u);
        tests++; if (n !== R) begin fails++; $display("FAIL first_tick: got %0d expected %0d", n, R); end
    endtask

    task automatic test_vectors();
        int bhi, ue, gc;
        logic b80, u80, u81;
        logic [5:0][11:0] g, e;
        e = {12'd2197, 12'd256, 12'd0, 12'd0, 12'd1024, 12'd4094};
        observe(0, 0, bhi, ue, gc, b80, u80, u81, g);
        tests++; if (bhi !== 79) begin fails++; $display("FAIL vec_busy_len: got %0d expected 79", bhi); end
        tests++; if (ue !== 0) begin fails++; $display("FAIL vec_early_upd: got %0d expected 0", ue); end
        tests++; if (gc !== 0) begin fails++; $display("FAIL vec_gain_glitch: got %0d expected 0", gc); end
        tests++; if (b80 !== 1'b0) begin fails++; $display("FAIL vec_busy80: got %b expected 0", b80); end
        tests++; if (u80 !== 1'b1) begin fails++; $display("FAIL vec_upd80: got %b expected 1", u80); end
        tests++; if (u81 !== 1'b0) begin fails++; $display("FAIL vec_upd81: got %b expected 0", u81); end
        tests++; if (g !== e) begin fails++; $display("FAIL vec_gains: got %h expected %h", g, e); end
    endtask

    task automatic test_capture();
        int n, u, bhi, ue, gc;
        logic b80, u80, u81;
        logic [5:0][11:0] g, e;
        set_random(1);
        e = model();
        wait_start(n, u);
        observe(1, 0, bhi, ue, gc, b80, u80, u81, g);
        tests++; if (g !== e) begin fails++; $display("FAIL capture_snap: got %h expected %h", g, e); end
        wait_start(n, u);
        observe(0, 0, bhi, ue, gc, b80, u80, u81, g);
        tests++; if (g !== '0) begin fails++; $display("FAIL capture_zero: got %h expected 0", g); end
        tests++; if (u80 !== 1'b1) begin fails++; $display("FAIL capture_upd: got %b expected 1", u80); end
    endtask

    task automatic test_freeze();
        int n, u, seen, bhi, ue, gc;
        logic b80, u80, u81;
        logic [5:0][11:0] g, e;
        set_random(64);
        e = model();
        frz = 1'b1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            seen += int'(busy !== 1'b0 || upd !== 1'b0);
            @(negedge clk);
        end
        frz = 1'b0;
        wait_start(n, u);
        tests++; if (seen !== 0) begin fails++; $display("FAIL frz_block: got %0d active cycles expected 0", seen); end
        tests++; if (last_start - prev_start !== 2 * R) begin
            fails++; $display("FAIL frz_spacing: got %0d expected %0d", last_start - prev_start, 2 * R);
        end
        observe(0, 1, bhi, ue, gc, b80, u80, u81, g);
        tests++; if (bhi !== 79 || b80 !== 1'b0 || u80 !== 1'b1) begin
            fails++; $display("FAIL frz_mid_timing: got busy %0d/%b upd %b expected 79/0/1", bhi, b80, u80);
        end
        tests++; if (g !== e) begin fails++; $display("FAIL frz_gains: got %h expected %h", g, e); end
    endtask

    task automatic test_reset_mid();
        int n, u, bhi, ue, gc;
        logic b80, u80, u81;
        logic [5:0][11:0] g, e;
        set_random(64);
        e = model();
        wait_start(n, u);
        repeat (39) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        tests++; if (gout !== '0) begin fails++; $display("FAIL rstmid_gain: got %h expected 0", gout); end
        tests++; if (busy !== 1'b0 || upd !== 1'b0) begin
            fails++; $display("FAIL rstmid_ctrl: got busy %b upd %b expected 0 0", busy, upd);
        end
        rst_n = 1'b1;
        wait_start(n, u);
        tests++; if (n !== R) begin fails++; $display("FAIL rstmid_restart: got %0d expected %0d", n, R); end
        tests++; if (u !== 0) begin fails++; $display("FAIL rstmid_upd: got %0d expected 0", u); end
        observe(0, 0, bhi, ue, gc, b80, u80, u81, g);
        tests++; if (g !== e) begin fails++; $display("FAIL rstmid_gains: got %h expected %h", g, e); end
    endtask

    task automatic test_spacing();
        int n, u, bhi, ue, gc;
        logic b80, u80, u81;
        logic [5:0][11:0] g, e;
        set_random(0);
        e = model();
        for (int s = 0; s < 3; s++) begin
            wait_start(n, u);
            if (s > 0) begin
                tests++; if (last_start - prev_start !== R) begin
                    fails++; $display("FAIL spacing_%0d: got %0d expected %0d", s, last_start - prev_start, R);
                end
            end
            observe(0, 0, bhi, ue, gc, b80, u80, u81, g);
            tests++; if (u80 !== 1'b1 || u81 !== 1'b0 || gc !== 0) begin
                fails++; $display("FAIL spacing_upd_%0d: got upd %b%b changes %0d expected 10 0", s, u80, u81, gc);
            end
            tests++; if (g !== e) begin fails++; $display("FAIL spacing_gain_%0d: got %h expected %h", s, g, e); end
        end
    endtask

    task automatic test_random();
        int n, u, bhi, ue, gc;
        logic b80, u80, u81;
        logic [5:0][11:0] g, e;
        for (int s = 0; s < 200; s++) begin
            set_random(0);
            e = model();
            wait_start(n, u);
            observe(0, s[0], bhi, ue, gc, b80, u80, u81, g);
            tests++; if (g !== e) begin fails++; $display("FAIL rand_gain_%0d: got %h expected %h", s, g, e); end
            tests++; if (bhi !== 79 || b80 !== 1'b0 || u80 !== 1'b1 || u81 !== 1'b0) begin
                fails++; $display("FAIL rand_timing_%0d: got busy %0d/%b upd %b%b expected 79/0 10", s, bhi, b80, u80, u81);
            end
        end
    endtask

    initial begin
        for (int c = 0; c < 6; c++) pot[c] = 12'd0;
        test_reset();
        test_vectors();
        test_capture();
        test_freeze();
        test_reset_mid();
        test_spacing();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
